// File: rtl/cache_line_refill.sv
// Line refill / writeback engine: splits one cache-line request into single-word bus transfers.
// Optional CACHE_REFILL_CRITICAL_WORD_FIRST_EN starts reads at the requested word and adds crit_valid/crit_word.
module cache_line_refill #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LINE_WIDTH-1:0]   req_wline,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [LINE_WIDTH-1:0]   resp_rline,
  output logic                    bus_cyc,
  output logic                    bus_stb,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_adr,
  output logic [DATA_WIDTH-1:0]   bus_dat_o,
  output logic [DATA_WIDTH/8-1:0] bus_sel,
  input  logic [DATA_WIDTH-1:0]   bus_dat_i,
  input  logic                    bus_ack,
  input  logic                    bus_err
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  ,
  output logic                    crit_valid,
  output logic [DATA_WIDTH-1:0]   crit_word
`endif
);

  localparam int unsigned DATA_PER_LINE = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned OFF_W         = $clog2(DATA_PER_LINE);
  localparam int unsigned BYTE_OFF      = $clog2(DATA_WIDTH / 8);
  localparam int unsigned LO            = OFF_W + BYTE_OFF;
  localparam int unsigned BASE_W        = ADDR_WIDTH - LO;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [BASE_W-1:0]       base_q, base_d;
  logic [LINE_WIDTH-1:0]   wline_q, wline_d;
  logic [OFF_W-1:0]        k_q, k_d;
  logic [OFF_W:0]          cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]   rline_q, rline_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [OFF_W-1:0]        k0;
  logic                    unused_addr_bits;

  // Low address bits only select the starting word (when enabled); the rest are don't-care.
  assign unused_addr_bits = ^req_addr[LO-1:0];

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic                    crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0]   crit_word_q, crit_word_d;
  assign k0         = req_write ? '0 : req_addr[LO-1:BYTE_OFF];
  assign crit_valid = crit_valid_q;
  assign crit_word  = crit_word_q;
`else
  assign k0 = '0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    base_d       = base_q;
    wline_d      = wline_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    rline_d      = rline_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    crit_valid_d = 1'b0;
    crit_word_d  = crit_word_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          base_d      = req_addr[ADDR_WIDTH-1:LO];
          wline_d     = req_wline;
          k_d         = k0;
          cnt_d       = '0;
          rline_d     = '0;
          req_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = req_write;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (bus_err) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          we_d         = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = DONE;
        end else if (bus_ack) begin
          // Slot chosen by word index, so wrapped fetch order still lands correctly
          for (int unsigned i = 0; i < DATA_PER_LINE; i++) begin
            if (!write_q && k_q == OFF_W'(i)) rline_d[i*DATA_WIDTH +: DATA_WIDTH] = bus_dat_i;
          end
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
          if (!write_q && cnt_q == '0) begin
            crit_valid_d = 1'b1;
            crit_word_d  = bus_dat_i;
          end
`endif
          k_d   = k_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == (OFF_W+1)'(DATA_PER_LINE)) begin
            cyc_d        = 1'b0;
            stb_d        = 1'b0;
            we_d         = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == XFER) begin
      adr_d = {base_d, k_d, {BYTE_OFF{1'b0}}};
      for (int unsigned i = 0; i < DATA_PER_LINE; i++) begin
        if (k_d == OFF_W'(i)) dat_d = wline_d[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      base_q       <= '0;
      wline_q      <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      rline_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      base_q       <= base_d;
      wline_q      <= wline_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      rline_q      <= rline_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rline = rline_q;
  assign bus_cyc    = cyc_q;
  assign bus_stb    = stb_q;
  assign bus_we     = we_q;
  assign bus_adr    = adr_q;
  assign bus_dat_o  = dat_q;
  assign bus_sel    = '1;

endmodule

// File: tb/tb_cache_line_refill.sv
// Self-checking bench for cache_line_refill: directed table, reset-abort sequence, randomized transfers.
module tb_cache_line_refill;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;
  localparam int N = LW / DW;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            req_valid, req_ready, req_write;
  logic [AW-1:0]   req_addr;
  logic [LW-1:0]   req_wline;
  logic            resp_valid, resp_err;
  logic [LW-1:0]   resp_rline;
  logic            bus_cyc, bus_stb, bus_we;
  logic [AW-1:0]   bus_adr;
  logic [DW-1:0]   bus_dat_o;
  logic [DW/8-1:0] bus_sel;
  logic [DW-1:0]   bus_dat_i;
  logic            bus_ack, bus_err;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic            crit_valid;
  logic [DW-1:0]   crit_word;
`endif

  cache_line_refill dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wline(req_wline),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rline(resp_rline),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_dat_o(bus_dat_o), .bus_sel(bus_sel), .bus_dat_i(bus_dat_i),
    .bus_ack(bus_ack), .bus_err(bus_err)
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    , .crit_valid(crit_valid), .crit_word(crit_word)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit            prev_valid = 1'b0;
  logic [LW-1:0] prev_line = '0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents seen by the bus slave
  function automatic logic [31:0] mem_f(input logic [31:0] a, input int mode);
    if (mode == 0) return 32'h1000 + 32'(a[4:2]);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic int k0_f(input bit w, input logic [31:0] a);
    return (CWF && !w) ? int'(a[4:2]) : 0;
  endfunction

  task automatic drive_noise(input bit noise);
    bus_ack   = noise ? 1'($urandom % 2) : 1'b0;
    bus_err   = noise ? 1'($urandom % 2) : 1'b0;
    bus_dat_i = $urandom;
  endtask

  // One line request: acts as the bus slave and checks every bus cycle against the arithmetic model.
  task automatic do_req(input bit w, input logic [31:0] addr, input logic [LW-1:0] wl,
                        input int waits, input int err_at, input int rst_at, input int mode,
                        input bit noise, output int lat, output bit got_err);
    logic [31:0]   base, exp_a, hold_a, hold_d;
    logic [LW-1:0] exp_line;
    int k0, npres, nok, c, widx, wcnt, pos;
    bit done;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    int first_c;
    logic [31:0] crit_exp;
    first_c = -1;
    crit_exp = '0;
`endif
    base  = {addr[31:5], 5'b0};
    k0    = k0_f(w, addr);
    npres = (err_at >= 0) ? err_at + 1 : N;
    nok   = (err_at >= 0) ? err_at : N;
    exp_line = '0;
    for (int s = 0; s < N; s++) begin
      pos = (s - k0 + N) % N;
      if (pos < nok) exp_line[s*DW +: DW] = mem_f(base + 32'(4*s), mode);
    end
    lat = -1; got_err = 1'b0; c = 0; widx = 0; wcnt = 0; done = 1'b0;
    hold_a = '0; hold_d = '0;

    @(negedge clk);
    chk("ready_idle", req_ready, 1'b1);
    chk("resp_single_pulse", resp_valid, 1'b0);
    if (prev_valid) chk("rline_hold", resp_rline, prev_line);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wline = wl;
    drive_noise(noise);

    while (!done) begin
      @(negedge clk);
      c++;
      req_valid = noise ? 1'($urandom % 2) : 1'b0;
      req_write = 1'($urandom % 2);
      req_addr  = $urandom;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      chk("crit_valid", crit_valid, (first_c >= 0 && c == first_c + 1));
      if (first_c >= 0 && c == first_c + 1) chk("crit_word", crit_word, crit_exp);
`endif
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("rst_cyc", bus_cyc, 1'b0);
        chk("rst_stb", bus_stb, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_no_resp", resp_valid, 1'b0);
        rst = 1'b1; req_valid = 1'b0;
        repeat (12) begin
          drive_noise(noise);
          @(negedge clk);
          chk("no_resp_after_rst", resp_valid, 1'b0);
        end
        prev_valid = 1'b0;
        done = 1'b1;
      end else if (resp_valid) begin
        lat = c; got_err = resp_err; req_valid = 1'b0;
        drive_noise(noise);
        done = 1'b1;
      end else if (c > 400) begin
        checks++; errors++;
        $display("FAIL timeout: no resp_valid after %0d cycles, required one", c);
        req_valid = 1'b0;
        done = 1'b1;
      end else begin
        chk("bus_cyc", bus_cyc, 1'b1);
        chk("bus_stb", bus_stb, 1'b1);
        chk("bus_sel", bus_sel, 4'hF);
        if (wcnt == 0) begin
          exp_a = base + 32'(4 * ((k0 + widx) % N));
          chk("bus_adr", bus_adr, exp_a);
          chk("bus_we", bus_we, w);
          chk("bus_dat_o", bus_dat_o, wl[((k0 + widx) % N)*DW +: DW]);
          hold_a = bus_adr; hold_d = bus_dat_o;
        end else begin
          chk("adr_hold", bus_adr, hold_a);
          chk("dat_hold", bus_dat_o, hold_d);
        end
        if (wcnt == waits) begin
          bus_dat_i = mem_f(bus_adr, mode);
          if (widx == err_at) begin
            bus_err = 1'b1;
            bus_ack = 1'($urandom % 2);
          end else begin
            bus_err = 1'b0;
            bus_ack = 1'b1;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
            if (!w && widx == 0) begin
              first_c = c;
              crit_exp = bus_dat_i;
            end
`endif
          end
          widx++; wcnt = 0;
        end else begin
          bus_ack = 1'b0; bus_err = 1'b0; bus_dat_i = $urandom;
          wcnt++;
        end
        if (c == rst_at) rst = 1'b0;
      end
    end
    if (lat >= 0) begin
      chk("word_count", widx, npres);
      if (!w) chk("resp_rline", resp_rline, exp_line);
      prev_valid = !w;
      prev_line  = exp_line;
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] addr;
    int          waits;
    int          err_at;
    int          mode;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [LW-1:0] wl;
    int  lat, waits, err_at, gap;
    bit  ge, w;
    logic [31:0] a;

    vecs[0] = '{1'b0, 32'h8000_0040, 0, -1, 0, 1'b0, 9};
    vecs[1] = '{1'b0, 32'h8000_0040, 2, -1, 0, 1'b0, 25};
    vecs[2] = '{1'b1, 32'h0000_0100, 0, -1, 0, 1'b0, 9};
    vecs[3] = '{1'b0, 32'h8000_0040, 0,  3, 0, 1'b1, 5};
    vecs[4] = '{1'b0, 32'h0000_0154, 0, -1, 0, 1'b0, 9};
    vecs[5] = '{1'b1, 32'h0000_0200, 1,  7, 1, 1'b1, 17};
    vecs[6] = '{1'b0, 32'hFFFF_FFE4, 3, -1, 1, 1'b0, 33};

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wline = '0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_resp_err", resp_err, 1'b0);
    chk("reset_cyc", bus_cyc, 1'b0);
    chk("reset_stb", bus_stb, 1'b0);
    chk("reset_we", bus_we, 1'b0);
    chk("reset_adr", bus_adr, '0);
    chk("reset_dat_o", bus_dat_o, '0);
    chk("reset_rline", resp_rline, '0);
    rst = 1'b1;

    for (int i = 0; i < N; i++) wl[i*DW +: DW] = 32'hA0 + 32'(i);
    for (int v = 0; v < 7; v++) begin
      do_req(vecs[v].w, vecs[v].addr, wl, vecs[v].waits, vecs[v].err_at, -1,
             vecs[v].mode, 1'b0, lat, ge);
      chk($sformatf("latency_v%0d", v), lat, vecs[v].exp_lat);
      chk($sformatf("resp_err_v%0d", v), ge, vecs[v].exp_err);
    end

    // Reset during the fifth word of a refill, then a normal refill afterwards
    do_req(1'b0, 32'h8000_0040, wl, 0, -1, 5, 0, 1'b1, lat, ge);
    do_req(1'b0, 32'h8000_0040, wl, 0, -1, -1, 0, 1'b0, lat, ge);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_err", ge, 1'b0);

    for (int r = 0; r < 40; r++) begin
      w = 1'($urandom % 2);
      a = $urandom;
      for (int i = 0; i < N; i++) wl[i*DW +: DW] = $urandom;
      waits  = int'($urandom % 4);
      err_at = ($urandom % 4 == 0) ? int'($urandom % N) : -1;
      do_req(w, a, wl, waits, err_at, -1, 1, 1'b1, lat, ge);
      chk("rand_latency", lat, ((err_at >= 0) ? err_at + 1 : N) * (waits + 1) + 1);
      chk("rand_err", ge, err_at >= 0);
      gap = int'($urandom % 3);
      repeat (gap) begin
        @(negedge clk);
        drive_noise(1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Line-transfer engine between a set-associative cache and the single-word memory bus. It sits directly downstream of the cache.
- It accepts one line-granular request: a miss refill (read) or a dirty-line writeback (write).
- It splits the request into DATA_PER_LINE single-word Wishbone-style bus transactions.
- For reads, it assembles the returned words into a full line and hands the line back to the cache.

Parameters:
- DATA_WIDTH, 32, bus word width in bits.
- LINE_WIDTH, 256, cache line width in bits; must be a power-of-two multiple of DATA_WIDTH.
- ADDR_WIDTH, 32, byte address width.
- Derived: DATA_PER_LINE = LINE_WIDTH/DATA_WIDTH.
- Derived: OFF_W = log2(DATA_PER_LINE).
- Derived: BYTE_OFF = log2(DATA_WIDTH/8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  cache request valid.
- req_ready  out  1  engine idle, can accept a request.
- req_write  in  1  1 = writeback, 0 = refill.
- req_addr  in  ADDR_WIDTH  byte address; line-offset bits are used only by the optional feature.
- req_wline  in  LINE_WIDTH  line to write back; word i sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; 1 = bus error, transfer aborted.
- resp_rline  out  LINE_WIDTH  assembled refill line; valid with resp_valid when !req_write.
- bus_cyc  out  1  bus cycle active.
- bus_stb  out  1  word strobe.
- bus_we  out  1  write enable.
- bus_adr  out  ADDR_WIDTH  word address.
- bus_dat_o  out  DATA_WIDTH  write data.
- bus_sel  out  DATA_WIDTH/8  byte selects; always all ones.
- bus_dat_i  in  DATA_WIDTH  read data.
- bus_ack  in  1  word done.
- bus_err  in  1  word failed.

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; req_ready=1; resp_valid=0; resp_err=0; bus_cyc=0; bus_stb=0; bus_we=0; bus_adr=0; bus_dat_o=0; resp_rline=0; word counter=0.
- Reset mid-burst: cyc/stb drop at that edge; no response is ever issued for the aborted request.
- All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture req_write, the line base (req_addr with low OFF_W+BYTE_OFF bits zeroed) and req_wline.
  - Set start index k0 = 0 (see the optional feature); go XFER.
- XFER:
  - bus_cyc=bus_stb=1, bus_we=captured write.
  - bus_adr = base + k*(DATA_WIDTH/8).
  - bus_dat_o = captured word k.
  - req_ready=0.
  - stb and all bus outputs hold stable until bus_ack or bus_err.
  - On bus_ack with !bus_err:
    - For reads, store bus_dat_i into line slot k; slot placement is always by word index, never by arrival order.
    - Advance k modulo DATA_PER_LINE and increment the count.
    - When the count reaches DATA_PER_LINE, go DONE with cyc/stb=0 at that same edge.
  - On bus_err (takes priority over a simultaneous bus_ack): drop cyc/stb, set the err flag, go DONE.
- DONE:
  - resp_valid=1 for exactly one cycle; resp_err = err flag.
  - resp_rline holds the assembled line; words not received after an error are 0.
  - Next edge: IDLE with req_ready=1.
  - resp_rline holds its value until the next request is accepted.
- Latency with zero-wait ack (ack in the same cycle as stb):
  - accept edge T0 → stb high cycles T1..T8 (for 8 words) → resp_valid in cycle T9.
  - Each wait state adds one cycle.
- Back-to-back: a new request can be accepted in the cycle after resp_valid (IDLE); minimum gap is 1 cycle.
- req_valid outside IDLE is ignored; the cache holds it until req_ready.
- The bus_ack/bus_err level is ignored outside XFER.

Optional Feature:
CACHE_REFILL_CRITICAL_WORD_FIRST_EN
- Defined:
  - k0 = req_addr[OFF_W+BYTE_OFF-1:BYTE_OFF], so the requested word is fetched first.
  - Order wraps: k0, k0+1, …, DATA_PER_LINE-1, 0, …, k0-1.
  - Applies to reads only; writes always start at 0.
  - Adds output crit_valid (1 bit): pulses one cycle after the first successful read ack.
  - Adds output crit_word (DATA_WIDTH): that word, so the pipeline can restart early.
- Undefined: k0 = 0 always; crit_* ports absent.

Test Plan:
- Read, base 0x8000_0040, zero-wait ack, bus_dat_i = 0x1000+k → bus_adr 0x..40,0x..44,…,0x..5C on 8 consecutive cycles, bus_we=0, resp_valid at T9, resp_rline word i = 0x1000+i, resp_err=0.
- Read with ack delayed 2 cycles per word → each bus_adr held stable 3 cycles, stb never drops mid-line, resp_valid at T25.
- Writeback, req_wline word i = 0xA0+i, addr 0x100 → bus_we=1, bus_dat_o 0xA0..0xA7 at addr 0x100..0x11C, resp_valid with resp_err=0.
- Read with bus_err on the 4th word → cyc/stb low the next cycle, resp_valid=1 with resp_err=1, words 0-2 valid and words 3-7 = 0, req_ready=1 the following cycle.
- rst=0 during word 5 of a read → next cycle cyc=stb=0 and req_ready=1; no resp_valid ever issued; a new request then completes normally.
- With CACHE_REFILL_CRITICAL_WORD_FIRST_EN, read addr 0x154 (word 5), zero-wait → word order 5,6,7,0,1,2,3,4; crit_valid at T2 with crit_word = word 5; resp_rline slots correct.
